// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and constants for the on-chip RAM two-master arbiter.
// Contents: bus widths, populated word count, request bundle and the
// read pipeline record that tracks one outstanding read return.
package onchip_mem_arb_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 10000;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } avm_req_t;

  typedef struct packed {
    logic valid;
    logic owner;  // 0 = m0, 1 = m1
    logic oor;    // address was out of range, return zero
  } rd_pend_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bundle of both Avalon-MM master ports plus the RAM s1 port.
// slave modport: arbiter view (accepts master requests, drives the RAM).
// master modport: environment view (masters and the RAM model).
interface onchip_mem_arbiter_if;
  import onchip_mem_arb_pkg::*;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-request round-robin arbiter with a registered priority pointer.
// Ports: clk, reset (sync, active-high), req[1:0], advance, gnt[1:0] one-hot.
// Grant is combinational; the pointer moves to the loser on each advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio;  // index of the master favoured on contention

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (advance) begin
      // m0 granted -> favour m1 next, m1 granted -> favour m0 next
      prio <= gnt[0];
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates m0/m1 onto the single-port on-chip RAM, one access per cycle.
// Ports: clk, reset (sync, active-high), bus (slave modport: masters + RAM).
// Writes complete at issue; reads return 1 cycle after issue; out-of-range
// writes are dropped and out-of-range reads return zero.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  onchip_mem_arbiter_if.slave  bus
);

  avm_req_t  req0, req1, sel;
  logic [1:0] req_vec, gnt;
  logic       granted, in_range, ret0, ret1;
  rd_pend_t   rd_pend;

  assign req0 = '{address: bus.m0_address, byteenable: bus.m0_byteenable,
                  read: bus.m0_read, write: bus.m0_write,
                  writedata: bus.m0_writedata};
  assign req1 = '{address: bus.m1_address, byteenable: bus.m1_byteenable,
                  read: bus.m1_read, write: bus.m1_write,
                  writedata: bus.m1_writedata};

  // Masking requests with reset guarantees no grant while in reset.
  assign req_vec = {req1.read | req1.write, req0.read | req0.write} & {2{~reset}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_vec),
    .advance (granted),
    .gnt     (gnt)
  );

  assign granted  = |gnt;
  // Default to m0 when idle so the RAM inputs stay quiet.
  assign sel      = gnt[1] ? req1 : req0;
  assign in_range = sel.address < ADDR_W'(NUM_WORDS);

  assign bus.mem_address    = sel.address;
  assign bus.mem_byteenable = sel.byteenable;
  assign bus.mem_writedata  = sel.writedata;
  assign bus.mem_chipselect = granted & in_range;
  assign bus.mem_write      = granted & in_range & sel.write;
  assign bus.mem_clken      = ~reset;

  assign bus.m0_waitrequest = reset | (req_vec[0] & ~gnt[0]);
  assign bus.m1_waitrequest = reset | (req_vec[1] & ~gnt[1]);

  // Read+write together is treated as a write: no return is scheduled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= '0;
    end else begin
      rd_pend.valid <= granted & sel.read & ~sel.write;
      rd_pend.owner <= gnt[1];
      rd_pend.oor   <= ~in_range;
    end
  end

  // Gating with reset drops a read issued just before reset was asserted.
  assign ret0 = rd_pend.valid & ~reset & ~rd_pend.owner;
  assign ret1 = rd_pend.valid & ~reset &  rd_pend.owner;

  assign bus.m0_readdatavalid = ret0;
  assign bus.m1_readdatavalid = ret1;
  assign bus.m0_readdata = (ret0 & ~rd_pend.oor) ? bus.mem_readdata : '0;
  assign bus.m1_readdata = (ret1 & ~rd_pend.oor) ? bus.mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM model
// (registered address, unregistered q, byte-lane writes).
module tb_onchip_mem_arbiter;
  import onchip_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter_if bus ();

  onchip_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM model
  logic [DATA_W-1:0] ram [0:16383];
  logic [ADDR_W-1:0] addr_q;

  always @(posedge clk) begin
    if (bus.mem_clken) begin
      addr_q <= bus.mem_address;
      if (bus.mem_chipselect && bus.mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
      end
    end
  end

  assign bus.mem_readdata = ram[addr_q];

  task automatic drive(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    if (m == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_writedata = d; bus.m0_byteenable = be;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_writedata = d; bus.m1_byteenable = be;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic single_write(input int m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [BE_W-1:0] be);
    @(negedge clk); drive(m, 1'b0, 1'b1, a, d, be);
    @(negedge clk); idle();
  endtask

  task automatic single_read(input int m, input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] q,
                             output logic v);
    @(negedge clk); drive(m, 1'b1, 1'b0, a, '0, 4'hF);
    @(negedge clk); idle(); #1;
    q = (m == 0) ? bus.m0_readdata : bus.m1_readdata;
    v = (m == 0) ? bus.m0_readdatavalid : bus.m1_readdatavalid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    drive(0, 1'b1, 1'b0, 14'h0010, '0, 4'hF);  // request during reset must not be granted
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b expected 1", bus.m0_waitrequest); end
      checks++; if (bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b expected 1", bus.m1_waitrequest); end
      checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b%b expected 00", bus.m1_readdatavalid, bus.m0_readdatavalid); end
      checks++; if (bus.m0_readdata !== 32'h0 || bus.m1_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0/0", bus.m0_readdata, bus.m1_readdata); end
      checks++; if (bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_cs_we: got %b%b expected 00", bus.mem_chipselect, bus.mem_write); end
      checks++; if (bus.mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b expected 0", bus.mem_clken); end
    end
    @(negedge clk); reset = 1'b0; idle(); #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.mem_clken !== 1'b1) begin errors++; $display("FAIL rst_release: got rdv=%b clken=%b expected rdv=0 clken=1", bus.m0_readdatavalid, bus.mem_clken); end
  endtask

  task automatic test_basic();
    @(negedge clk); drive(0, 1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF); #1;
    checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL basic_wr_wait: got %b expected 0", bus.m0_waitrequest); end
    checks++; if ({bus.mem_chipselect, bus.mem_write} !== 2'b11 || bus.mem_address !== 14'h0010) begin errors++; $display("FAIL basic_wr_issue: got cs/we=%b%b addr=%h expected 11 0010", bus.mem_chipselect, bus.mem_write, bus.mem_address); end
    @(negedge clk); drive(0, 1'b1, 1'b0, 14'h0010, '0, 4'hF); #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL basic_rd_issue: got wait=%b we=%b expected 0 0", bus.m0_waitrequest, bus.mem_write); end
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL basic_wr_no_rdv: got %b expected 0", bus.m0_readdatavalid); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_ret: got v=%b d=%h expected 1 deadbeef", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (bus.m1_readdatavalid !== 1'b0 || bus.m1_readdata !== 32'h0) begin errors++; $display("FAIL basic_m1_idle: got v=%b d=%h expected 0 0", bus.m1_readdatavalid, bus.m1_readdata); end
    @(negedge clk); #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL basic_rdv_once: got %b expected 0", bus.m0_readdatavalid); end
  endtask

  task automatic test_contention();
    int g, p;
    single_write(0, 14'h0001, 32'h11111111, 4'hF);
    single_write(1, 14'h0002, 32'h22222222, 4'hF);  // m1 granted last, so m0 is favoured next
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 14'h0001, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 14'h0002, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      g = i % 2;
      checks++; if (bus.m0_waitrequest !== (g == 1) || bus.m1_waitrequest !== (g == 0)) begin errors++; $display("FAIL cont_grant[%0d]: got wait m0=%b m1=%b expected grant m%0d", i, bus.m0_waitrequest, bus.m1_waitrequest, g); end
      checks++; if (bus.mem_address !== ((g == 1) ? 14'h0002 : 14'h0001)) begin errors++; $display("FAIL cont_addr[%0d]: got %h expected m%0d address", i, bus.mem_address, g); end
      if (i > 0) begin
        p = (i - 1) % 2;
        checks++; if (bus.m0_readdatavalid !== (p == 0) || bus.m1_readdatavalid !== (p == 1)) begin errors++; $display("FAIL cont_rdv[%0d]: got %b%b expected owner m%0d", i, bus.m1_readdatavalid, bus.m0_readdatavalid, p); end
        checks++; if (((p == 0) ? bus.m0_readdata : bus.m1_readdata) !== ((p == 0) ? 32'h11111111 : 32'h22222222)) begin errors++; $display("FAIL cont_data[%0d]: got %h/%h for owner m%0d", i, bus.m0_readdata, bus.m1_readdata, p); end
      end
    end
    @(negedge clk); idle(); #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h22222222 || bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL cont_tail: got m1 v=%b d=%h m0 v=%b expected 1 22222222 0", bus.m1_readdatavalid, bus.m1_readdata, bus.m0_readdatavalid); end
  endtask

  task automatic test_byte_lanes();
    logic [DATA_W-1:0] q;
    logic v;
    single_write(0, 14'h0100, 32'h00000000, 4'hF);
    single_write(0, 14'h0100, 32'hAABBCCDD, 4'h5);
    single_read(0, 14'h0100, q, v);
    checks++; if (v !== 1'b1 || q !== 32'h00BB00DD) begin errors++; $display("FAIL byte_lanes: got v=%b d=%h expected 1 00bb00dd", v, q); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk); drive(1, 1'b0, 1'b1, 14'd9999, 32'h12345678, 4'hF); #1;
    checks++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL oor_wr9999: got cs/we=%b%b expected 11", bus.mem_chipselect, bus.mem_write); end
    @(negedge clk); drive(1, 1'b0, 1'b1, 14'd10000, 32'h12345678, 4'hF); #1;
    checks++; if (bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0 || bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_wr10000: got cs=%b we=%b wait=%b expected 0 0 0", bus.mem_chipselect, bus.mem_write, bus.m1_waitrequest); end
    @(negedge clk); drive(1, 1'b1, 1'b0, 14'd9999, '0, 4'hF); #1;
    checks++; if (bus.mem_chipselect !== 1'b1) begin errors++; $display("FAIL oor_rd9999_cs: got %b expected 1", bus.mem_chipselect); end
    @(negedge clk); drive(1, 1'b1, 1'b0, 14'd10000, '0, 4'hF); #1;
    checks++; if (bus.mem_chipselect !== 1'b0 || bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_rd10000_issue: got cs=%b wait=%b expected 0 0", bus.mem_chipselect, bus.m1_waitrequest); end
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h12345678) begin errors++; $display("FAIL oor_ret9999: got v=%b d=%h expected 1 12345678", bus.m1_readdatavalid, bus.m1_readdata); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h00000000) begin errors++; $display("FAIL oor_ret10000: got v=%b d=%h expected 1 00000000", bus.m1_readdatavalid, bus.m1_readdata); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); drive(0, 1'b1, 1'b0, 14'h0010, '0, 4'hF); #1;
    checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rmr_issue: got wait=%b expected 0", bus.m0_waitrequest); end
    @(negedge clk); reset = 1'b1;
    drive(0, 1'b1, 1'b0, 14'h0010, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 14'h0002, '0, 4'hF);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rmr_rdv[%0d]: got %b%b expected 00", c, bus.m1_readdatavalid, bus.m0_readdatavalid); end
      checks++; if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1 || bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL rmr_wait[%0d]: got w0=%b w1=%b cs=%b expected 1 1 0", c, bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_chipselect); end
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rmr_first_grant: got w0=%b w1=%b expected 0 1", bus.m0_waitrequest, bus.m1_waitrequest); end
    checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rmr_release_rdv: got %b%b expected 00", bus.m1_readdatavalid, bus.m0_readdatavalid); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmr_ret: got v=%b d=%h expected 1 deadbeef", bus.m0_readdatavalid, bus.m0_readdata); end
  endtask

  task automatic test_read_write_both();
    logic [DATA_W-1:0] q;
    logic v;
    @(negedge clk); drive(0, 1'b1, 1'b1, 14'h0020, 32'h5A5A5A5A, 4'hF); #1;
    checks++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1 || bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rw_issue: got cs=%b we=%b wait=%b expected 1 1 0", bus.mem_chipselect, bus.mem_write, bus.m0_waitrequest); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv: got %b expected 0", bus.m0_readdatavalid); end
    single_read(0, 14'h0020, q, v);
    checks++; if (v !== 1'b1 || q !== 32'h5A5A5A5A) begin errors++; $display("FAIL rw_readback: got v=%b d=%h expected 1 5a5a5a5a", v, q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_read();
    test_read_write_both();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
